// File: rtl/regfile_host.sv
// regfile_host
// Command front-end for an external two-read/one-write register file.
// Commands:
//   WRITE - single register write.
//   READ  - dual read, returned as one held response.
//   FILL  - writes base + 2*i into every entry.
//   DUMP  - reads the pair (i, i+REGS/2) for each i in the lower half,
//           giving one response per pair.
//
// Ports
//   clk, rst_n               : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready    : command handshake
//   cmd_op                   : 00 WRITE, 01 READ, 10 FILL, 11 DUMP
//   cmd_addr_a / cmd_addr_b  : write/read address A, read address B
//   cmd_data                 : write data or FILL base value
//   rsp_valid / rsp_ready    : response handshake
//   rsp_data_a / rsp_data_b  : captured read data
//   rsp_addr                 : address A belonging to the response
//   busy                     : high whenever a command is in progress
//   address_w/a/b, enable_w/a/b, In : register-file drive
//   OutA, OutB               : register-file read data, valid one cycle after
//                              the edge that sampled enable_a/enable_b
module regfile_host #(
  parameter int REGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_addr_a,
  input  logic [4:0]  cmd_addr_b,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data_a,
  output logic [31:0] rsp_data_b,
  output logic [4:0]  rsp_addr,
  output logic        busy,
  output logic [4:0]  address_w,
  output logic [4:0]  address_a,
  output logic [4:0]  address_b,
  output logic        enable_w,
  output logic        enable_a,
  output logic        enable_b,
  output logic [31:0] In,
  input  logic [31:0] OutA,
  input  logic [31:0] OutB
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR       = 3'd1;
  localparam logic [2:0] ST_FILL     = 3'd2;
  localparam logic [2:0] ST_RD_ISSUE = 3'd3;
  localparam logic [2:0] ST_RD_WAIT  = 3'd4;
  localparam logic [2:0] ST_RESP     = 3'd5;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;

  localparam logic [4:0] LAST_ADDR = 5'(REGS - 1);
  localparam logic [4:0] HALF      = 5'(REGS / 2);
  localparam logic [4:0] DUMP_LAST = 5'(REGS / 2 - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  addr_a_q, addr_a_d;
  logic [4:0]  addr_b_q, addr_b_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rsp_data_a_q, rsp_data_a_d;
  logic [31:0] rsp_data_b_q, rsp_data_b_d;
  logic [4:0]  rsp_addr_q, rsp_addr_d;

  logic [4:0]  rd_addr_a, rd_addr_b;

  // DUMP walks the loop counter over the lower half and pairs it with the
  // matching upper-half entry; READ uses the latched command addresses.
  always_comb begin
    rd_addr_a = addr_a_q;
    rd_addr_b = addr_b_q;
    if (op_q == OP_DUMP) begin
      rd_addr_a = cnt_q;
      rd_addr_b = cnt_q + HALF;
    end
  end

  // Sequencing. Commands are latched on acceptance so later changes on the
  // cmd_* inputs cannot disturb the operation in progress.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    rsp_data_a_d = rsp_data_a_q;
    rsp_data_b_d = rsp_data_b_q;
    rsp_addr_d   = rsp_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          addr_a_d = cmd_addr_a;
          addr_b_d = cmd_addr_b;
          data_d   = cmd_data;
          cnt_d    = 5'd0;
          case (cmd_op)
            OP_WRITE: state_d = ST_WR;
            OP_FILL:  state_d = ST_FILL;
            default:  state_d = ST_RD_ISSUE;
          endcase
        end
      end
      ST_WR: state_d = ST_IDLE;
      ST_FILL: begin
        // The counter only ever wraps back to zero here, on the last write.
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = 5'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        // Register-file data is valid in this cycle, one edge after issue.
        rsp_data_a_d = OutA;
        rsp_data_b_d = OutB;
        rsp_addr_d   = rd_addr_a;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (op_q == OP_DUMP && cnt_q != DUMP_LAST) begin
            cnt_d   = cnt_q + 5'd1;
            state_d = ST_RD_ISSUE;
          end else begin
            cnt_d   = 5'd0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register-file drive decodes straight from state so an asynchronous reset
  // drops every enable immediately. Idle buses are forced to zero.
  always_comb begin
    enable_w  = 1'b0;
    address_w = 5'd0;
    In        = 32'd0;
    enable_a  = 1'b0;
    enable_b  = 1'b0;
    address_a = 5'd0;
    address_b = 5'd0;
    case (state_q)
      ST_WR: begin
        enable_w  = 1'b1;
        address_w = addr_a_q;
        In        = data_q;
      end
      ST_FILL: begin
        enable_w  = 1'b1;
        address_w = cnt_q;
        In        = data_q + {26'd0, cnt_q, 1'b0};
      end
      ST_RD_ISSUE: begin
        enable_a  = 1'b1;
        enable_b  = 1'b1;
        address_a = rd_addr_a;
        address_b = rd_addr_b;
      end
      default: ;
    endcase
  end

  assign cmd_ready  = rst_n && (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_data_a = rsp_data_a_q;
  assign rsp_data_b = rsp_data_b_q;
  assign rsp_addr   = rsp_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_WRITE;
      addr_a_q     <= 5'd0;
      addr_b_q     <= 5'd0;
      data_q       <= 32'd0;
      cnt_q        <= 5'd0;
      rsp_data_a_q <= 32'd0;
      rsp_data_b_q <= 32'd0;
      rsp_addr_q   <= 5'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      rsp_data_a_q <= rsp_data_a_d;
      rsp_data_b_q <= rsp_data_b_d;
      rsp_addr_q   <= rsp_addr_d;
    end
  end

endmodule

// File: doc/regfile_host.md
REGFILE_HOST -- requirements
Module: regfile_host

Interface
REQ-001 SHALL have parameter REGS, default 32, number of register-file entries addressed (address width 5).
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have cmd_valid  input  1  command offered.
REQ-005 SHALL have cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-006 SHALL have cmd_op  input  2  00 WRITE, 01 READ, 10 FILL, 11 DUMP.
REQ-007 SHALL have cmd_addr_a  input  5  write/read address A.
REQ-008 SHALL have cmd_addr_b  input  5  read address B.
REQ-009 SHALL have cmd_data  input  32  write data, or FILL base value.
REQ-010 SHALL have rsp_valid  output  1  read response held valid.
REQ-011 SHALL have rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high at a rising edge.
REQ-012 SHALL have rsp_data_a / rsp_data_b  output  32 each  captured read data.
REQ-013 SHALL have rsp_addr  output  5  address A belonging to the response.
REQ-014 SHALL have busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have address_w, address_a, address_b  output  5 each; enable_w, enable_a, enable_b  output  1 each; In  output  32: register-file drive.
REQ-016 SHALL have OutA, OutB  input  32 each  register-file read data, valid in the cycle after the edge that sampled enable_a/enable_b high.

Function
REQ-017 SHALL implement states IDLE, WR, FILL, RD_ISSUE, RD_WAIT, RESP.
REQ-018 SHALL drive cmd_ready = 1 only in IDLE with rst_n high.
REQ-019 On WRITE accept: SHALL enter WR, assert enable_w for exactly one cycle with address_w=cmd_addr_a and In=cmd_data, then return to IDLE; no response.
REQ-020 On READ accept: RD_ISSUE (one cycle, enable_a=enable_b=1, address_a=cmd_addr_a, address_b=cmd_addr_b) -> RD_WAIT (one cycle, captures OutA/OutB into rsp_data_a/b) -> RESP.
REQ-021 In RESP: SHALL hold rsp_valid=1 and all rsp_* stable until rsp_ready; on handshake, READ returns to IDLE.
REQ-022 On FILL accept: SHALL write addresses 0..31 on 32 consecutive cycles with In = cmd_data + 2*i (mod 2^32) and enable_w=1, then IDLE; no response.
REQ-023 On DUMP accept: for i = 0..15 SHALL run RD_ISSUE/RD_WAIT/RESP with address_a=i, address_b=i+16, rsp_addr=i; after the handshake for i=15, IDLE.
REQ-024 SHALL drive each enable low and its address (and In) to 0 in every cycle it is not asserted.
REQ-025 SHALL never assert enable_w together with enable_a or enable_b.
REQ-026 SHALL latch cmd_op, addresses and data at acceptance; later cmd_* changes SHALL NOT affect the command in progress.
REQ-027 A 5-bit loop counter SHALL wrap from 31 to 0 only at FILL termination; no out-of-range address is ever driven.
REQ-028 rsp_ready high outside RESP SHALL have no effect; cmd_valid outside IDLE SHALL be ignored (not queued).

Reset
REQ-029 While rst_n is low: state IDLE, cmd_ready=0, busy=0, rsp_valid=0, rsp_data_a/b=0, rsp_addr=0, all enables, addresses and In = 0, counter = 0.
REQ-030 Reset asserted mid-FILL or mid-DUMP SHALL abort immediately with no further register-file access; the first command is accepted on the first rising edge after release.

Verification
REQ-031 WRITE addr 5 data 0xDEADBEEF -> exactly one cycle with enable_w=1, address_w=5, In=0xDEADBEEF; busy high for one cycle.
REQ-032 FILL base 0 then READ a=7 b=31 -> rsp_data_a=14, rsp_data_b=62, rsp_addr=7, four cycles from accept to rsp_valid.
REQ-033 DUMP after FILL base 0 with rsp_ready low for 3 cycles on response i=4 -> rsp_* stable during the stall; 16 responses, pair (2i, 2i+32).
REQ-034 FILL base 0xFFFFFFF0 -> address 31 receives 0x0000002E (wrap-around).
REQ-035 rst_n pulsed low at FILL cycle 10 -> all enables drop asynchronously; cmd_ready=1 on first edge after release; addresses 10..31 unwritten.
REQ-036 cmd_valid held high with changing cmd_* during READ -> ignored; only the latched command completes.
